// File: rtl/rom_loader.sv
// rom_loader: framed byte-stream loader for the HACK instruction ROM.
// Frame: SYNC, LEN_HI, LEN_LO, N x (HI, LO), CHK (XOR of the data bytes).
// The CPU is held in reset until a complete frame with a good checksum lands.
module rom_loader #(
    parameter int         ADDR_W    = 15,
    parameter int         MAX_WORDS = 32768,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_data,
    output logic              rom_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // One extra index bit so a full-ROM frame can count up to 2**ADDR_W.
    localparam int IDX_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t            state_q;
    logic [15:0]       len_q;
    logic [7:0]        hi_q;
    logic [7:0]        chk_q;
    logic [IDX_W-1:0]  widx_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [15:0]       rom_data_q;
    logic              rom_we_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              error_q;

    logic              xfer;
    logic [15:0]       len_d;
    logic [IDX_W-1:0]  widx_d;
    logic              last_word;

    // Byte acceptance is a pure function of state; DONE/ERROR consume nothing.
    always_comb begin
        in_ready = (state_q != S_DONE) && (state_q != S_ERROR);
    end

    assign xfer      = in_valid && in_ready;
    assign len_d     = {len_q[15:8], in_data};
    assign widx_d    = widx_q + IDX_W'(1);
    assign last_word = (32'(widx_d) == 32'(len_q));

    // Frame parser, word writer and status outputs in one registered FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            hi_q       <= '0;
            chk_q      <= '0;
            widx_q     <= '0;
            rom_addr_q <= '0;
            rom_data_q <= '0;
            rom_we_q   <= 1'b0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            rom_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Anything that is not a sync byte is dropped, which lets
                    // the loader resynchronise on line noise.
                    if (xfer && in_data == SYNC_BYTE) begin
                        state_q <= S_LEN_HI;
                        chk_q   <= '0;
                        widx_q  <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len_q[15:8] <= in_data;
                        state_q     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_q[7:0] <= in_data;
                        if (int'(len_d) > MAX_WORDS) begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end else if (len_d == 16'd0) begin
                            state_q <= S_CHECK;
                        end else begin
                            state_q <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (xfer) begin
                        hi_q    <= in_data;
                        chk_q   <= chk_q ^ in_data;
                        state_q <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    // The write is fire-and-forget, so the next byte may be
                    // taken while rom_we is still high.
                    if (xfer) begin
                        chk_q      <= chk_q ^ in_data;
                        rom_data_q <= {hi_q, in_data};
                        rom_addr_q <= widx_q[ADDR_W-1:0];
                        rom_we_q   <= 1'b1;
                        widx_q     <= widx_d;
                        state_q    <= last_word ? S_CHECK : S_DATA_HI;
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        if (in_data == chk_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q    <= S_IDLE;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        cpu_hold_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rom_addr = rom_addr_q;
    assign rom_data = rom_data_q;
    assign rom_we   = rom_we_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: stimulus queues expected ROM writes,
// a negedge monitor pops and compares each rom_we pulse.
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic        rom_we;
    logic        cpu_hold;
    logic        done;
    logic        error;

    typedef struct packed {
        logic [14:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t        exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] normal[8];

    rom_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rom_addr(rom_addr), .rom_data(rom_data), .rom_we(rom_we),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    function automatic void check(string nm, int unsigned act, int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endfunction

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h:%0h expected=none", rom_addr, rom_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", rom_addr, e.addr);
                check("write_data", rom_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 0;
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (in_ready) begin
                tick();
                ok = 1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
        repeat (gap) tick();
    endtask

    task automatic send_normal(input int gap, input logic [7:0] chk_byte);
        for (int i = 0; i < 7; i++) send_byte(normal[i], gap);
        send_byte(chk_byte, gap);
    endtask

    task automatic push_normal();
        exp_q.push_back('{addr: 15'd0, data: 16'h1234});
        exp_q.push_back('{addr: 15'd1, data: 16'hABCD});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_status(string nm, logic d, logic e, logic h, logic r);
        check({nm, "_done"}, done, d);
        check({nm, "_error"}, error, e);
        check({nm, "_hold"}, cpu_hold, h);
        check({nm, "_ready"}, in_ready, r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        normal = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tick(); tick();
        reset = 1'b0;
        // Reset state
        check_status("reset", 0, 0, 1, 1);
        check("reset_we", rom_we, 0);
        check("reset_addr", rom_addr, 0);
        check("reset_data", rom_data, 0);

        // Normal load
        push_normal();
        send_normal(0, 8'h40);
        check_status("normal", 1, 0, 0, 0);
        // Bytes offered in DONE are not consumed and nothing changes
        in_data = 8'hA5; in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        check_status("done_hold", 1, 0, 0, 0);
        pulse_start();
        check_status("rearm", 0, 0, 1, 1);

        // Bad checksum: writes still occur
        push_normal();
        send_normal(0, 8'h41);
        check_status("badchk", 0, 1, 1, 0);
        pulse_start();
        check_status("badchk_rearm", 0, 0, 1, 1);

        // Empty frame
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        check_status("empty_pre", 0, 0, 1, 1);
        send_byte(8'h00, 0);
        check_status("empty", 1, 0, 0, 0);
        pulse_start();

        // Oversize: 0x8001 words rejected right after LEN_LO
        send_byte(8'hA5, 0); send_byte(8'h80, 0); send_byte(8'h01, 0);
        check_status("oversize", 0, 1, 1, 0);
        pulse_start();

        // Resync garbage then the normal frame with 3-cycle gaps
        send_byte(8'h00, 3); send_byte(8'hFF, 3); send_byte(8'h3C, 3);
        push_normal();
        send_normal(3, 8'h40);
        check_status("gapped", 1, 0, 0, 0);
        pulse_start();

        // Reset after the 0x12 byte: no write, frame abandoned
        for (int i = 0; i < 4; i++) send_byte(normal[i], 0);
        reset = 1'b1; tick(); reset = 1'b0;
        tick();
        check_status("midreset", 0, 0, 1, 1);
        push_normal();
        send_normal(0, 8'h40);
        check_status("after_reset", 1, 0, 0, 0);
        pulse_start();

        // start while in DATA_LO is ignored
        for (int i = 0; i < 4; i++) send_byte(normal[i], 0);
        pulse_start();
        check_status("busy_start", 0, 0, 1, 1);
        push_normal();
        for (int i = 4; i < 8; i++) send_byte(normal[i], 0);
        check_status("busy_done", 1, 0, 0, 0);

        tick(); tick();
        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
